// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: loads K10 and emits K10..K0 over valid/ready,
// deriving each earlier round key with one registered S-box column per step.
module aes_inv_key_schedule #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EMIT, STEP1, STEP2} state_t;

    // Forward AES S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     round_q, round_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic [31:0]    sbox_q, sbox_d;
    logic           sbox_en;
    logic [31:0]    w0, w1, w2, w3, w3_new, sbox_in;

    assign w0      = key_q[127:96];
    assign w1      = key_q[95:64];
    assign w2      = key_q[63:32];
    assign w3      = key_q[31:0];
    assign w3_new  = w3 ^ w2;
    assign sbox_in = {w3_new[23:0], w3_new[31:24]};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        sbox_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'(NUM_ROUNDS);
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    valid_d = 1'b0;
                    if (round_q != 4'd0) begin
                        state_d = STEP1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            // w0 is kept until STEP2 because it is needed alongside the S-box result.
            STEP1: begin
                key_d   = {w0, w1 ^ w0, w2 ^ w1, w3_new};
                sbox_en = 1'b1;
                state_d = STEP2;
            end
            STEP2: begin
                key_d[127:96] = w0 ^ sbox_q ^ {rcon(round_q), 24'h000000};
                round_d       = round_q - 4'd1;
                valid_d       = 1'b1;
                state_d       = EMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sbox_d = sbox_en ? sub_word(sbox_in) : sbox_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            sbox_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            sbox_q  <= sbox_d;
        end
    end

    assign busy      = busy_q;
    assign key_out   = key_q;
    assign key_round = round_q;
    assign key_valid = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the reverse AES-128 key schedule; expected keys come from an
// independent forward expansion built on a GF(2^8)-derived S-box.
module tb_aes_inv_key_schedule;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         key_ready;
    logic         done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] exp_keys [0:10];
    logic [127:0] got_keys [0:10];

    aes_inv_key_schedule #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] vb;
        logic [7:0] cb;
        for (int v = 0; v < 256; v++) begin
            vb  = v[7:0];
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                cb = c[7:0];
                if (gmul(vb, cb) == 8'h01) inv = cb;
            end
            sb[vb] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] rcon_ref(input int i);
        logic [7:0] rc;
        rc = 8'h01;
        for (int k = 1; k < i; k++) rc = xtime(rc);
        return {rc, 24'h000000};
    endfunction

    function automatic logic [31:0] subword_ref(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // One forward expansion round: K(i-1) -> Ki.
    function automatic logic [127:0] fwd_step(input logic [127:0] k, input int i);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subword_ref({k[23:0], k[31:24]}) ^ rcon_ref(i);
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    task automatic expand(input logic [127:0] k0);
        exp_keys[0] = k0;
        for (int i = 1; i <= 10; i++) exp_keys[i] = fwd_step(exp_keys[i-1], i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode: 0 no stall, 1 backpressure, 2 start pulse at round 5, 3 start on final handshake
    task automatic run_seq(input logic [127:0] k10, input int mode, input bit use_exp, output int lat);
        int n;
        int s;
        int t0;
        key_in = k10;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        t0     = cyc;
        chk("k10_next_cycle", 128'({key_valid, busy, done}), 128'(3'b110));
        for (int r = 10; r >= 0; r--) begin
            if (r != 10) begin
                n = 0;
                while (key_valid !== 1'b1 && n < 16) begin
                    tick();
                    n++;
                end
                chk($sformatf("step_latency_r%0d", r), 128'(n), 128'(2));
            end
            chk($sformatf("key_round_r%0d", r), 128'(key_round), 128'(r));
            if (use_exp) chk($sformatf("key_out_r%0d", r), key_out, exp_keys[r]);
            got_keys[r] = key_out;
            s = 0;
            if (mode == 1) s = (r == 9) ? 5 : int'($urandom_range(0, 3));
            for (int j = 0; j < s; j++) begin
                tick();
                chk($sformatf("stall_key_r%0d", r), key_out, got_keys[r]);
                chk($sformatf("stall_ctl_r%0d", r), 128'({key_valid, done, key_round}), 128'({2'b10, 4'(r)}));
            end
            if (mode == 2 && r == 5) begin
                key_in = ~k10;
                start  = 1'b1;
                tick();
                start  = 1'b0;
                key_in = k10;
                chk("busy_start_key", key_out, got_keys[r]);
                chk("busy_start_ctl", 128'({busy, key_valid, key_round}), 128'({2'b11, 4'(r)}));
            end
            if (mode == 3 && r == 0) begin
                key_in = ~k10;
                start  = 1'b1;
            end
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
            start     = 1'b0;
        end
        chk("done_pulse", 128'({done, key_valid, busy}), 128'(3'b100));
        lat = cyc - t0 + 1;
    endtask

    task automatic chain_chk(input string tag, input logic [127:0] k10);
        chk({tag, "_k10"}, got_keys[10], k10);
        for (int i = 1; i <= 10; i++)
            chk($sformatf("%s_r%0d", tag, i - 1), fwd_step(got_keys[i-1], i), got_keys[i]);
    endtask

    initial begin
        int lat;
        int n;
        logic [127:0] k0;
        rst_n     = 1'b0;
        start     = 1'b0;
        key_in    = '0;
        key_ready = 1'b0;
        build_sbox();
        tick();
        tick();
        chk("reset_key", key_out, 128'h0);
        chk("reset_ctl", 128'({busy, key_valid, done, key_round}), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_ctl", 128'({busy, key_valid, done}), 128'h0);

        // FIPS-197 A.1 with ready always granted
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 1'b1, lat);
        chk("fips_r10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_r9", got_keys[9], 128'hac7766f319fadc2128d12941575c006e);
        chk("fips_r1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r0", got_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("fips_latency", 128'(lat), 128'(32));
        tick();
        chk("done_one_cycle", 128'({done, busy, key_valid}), 128'h0);

        // Backpressure, start while busy, start on final handshake
        run_seq(exp_keys[10], 1, 1'b1, lat);
        tick();
        run_seq(exp_keys[10], 2, 1'b1, lat);
        tick();
        run_seq(exp_keys[10], 3, 1'b1, lat);
        tick();
        chk("final_hs_start_ignored", 128'({busy, key_valid, done}), 128'h0);

        // Reset while in STEP1 of round 6
        key_in    = exp_keys[10];
        start     = 1'b1;
        tick();
        start     = 1'b0;
        key_ready = 1'b1;
        n = 0;
        while (!(key_valid === 1'b1 && key_round === 4'd6) && n < 40) begin
            tick();
            n++;
        end
        chk("reach_round6", 128'(n < 40), 128'(1));
        tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_key", key_out, 128'h0);
        chk("midreset_ctl", 128'({busy, key_valid, done, key_round}), 128'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        key_ready = 1'b0;
        repeat (4) tick();
        chk("post_reset_quiet", 128'({busy, key_valid, done, key_round}), 128'h0);
        expand(128'h000102030405060708090a0b0c0d0e0f);
        run_seq(exp_keys[10], 0, 1'b1, lat);
        chk("second_key_latency", 128'(lat), 128'(32));
        tick();

        // All-zero and all-ones K10, checked by forward-stepping every emitted key
        run_seq(128'h0, 0, 1'b0, lat);
        chain_chk("zero_chain", 128'h0);
        tick();
        run_seq({128{1'b1}}, 0, 1'b0, lat);
        chain_chk("ones_chain", {128{1'b1}});

        // Back-to-back random keys: start on the cycle done is high
        for (int k = 0; k < 100; k++) begin
            k0 = {$urandom, $urandom, $urandom, $urandom};
            expand(k0);
            run_seq(exp_keys[10], 0, 1'b1, lat);
            chk($sformatf("rand%0d_latency", k), 128'(lat), 128'(32));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
